// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared parameter defaults and operation encoding for the register bank
package reg_bank_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_WRAP  = 1;
    typedef enum logic [1:0] {OP_NONE, OP_WRITE, OP_INC, OP_CLEAR} op_t;
endpackage

// File: rtl/reg_cell.sv
// reg_cell: one bank entry with load, increment (wrap or saturate) and combinational overflow flag
module reg_cell
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WRAP  = DEF_WRAP
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_sclr,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_ovf
);
    logic [WIDTH-1:0] r_q;
    logic             w_full;
    assign w_full = &r_q;
    assign o_ovf  = i_inc & w_full & ~i_load & ~i_sclr;
    assign o_q    = r_q;
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_q <= '0;
        else if (i_sclr) r_q <= '0;
        else if (i_load) r_q <= i_d;
        else if (i_inc && !(w_full && WRAP == 0)) r_q <= r_q + WIDTH'(1);
    end
endmodule

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register bank with write/increment port, registered read port
// and a registered one-cycle overflow pulse.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  DEPTH = DEF_DEPTH,
    parameter int  WRAP  = DEF_WRAP,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sclr,
    input  logic             inen,
    input  logic             inc,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             oen,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             ovf
);
    op_t              w_op;
    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_inc;
    logic [DEPTH-1:0] w_ovf;
    logic [WIDTH-1:0] w_q [DEPTH];
    logic [WIDTH-1:0] w_rd;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_ovf;

    assign w_op = sclr ? OP_CLEAR : inen ? OP_WRITE : inc ? OP_INC : OP_NONE;

    // Addresses >= DEPTH match no cell, so they are silently dropped.
    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_cell
            assign w_load[g] = (w_op == OP_WRITE) && (wr_addr == AW'(g));
            assign w_inc[g]  = (w_op == OP_INC) && (wr_addr == AW'(g));
            reg_cell #(.WIDTH(WIDTH), .WRAP(WRAP)) u_cell (
                .clk    (clk),
                .clr    (clr),
                .i_sclr (w_op == OP_CLEAR),
                .i_load (w_load[g]),
                .i_inc  (w_inc[g]),
                .i_d    (data_in),
                .o_q    (w_q[g]),
                .o_ovf  (w_ovf[g])
            );
        end
    endgenerate

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < DEPTH; i++) w_rd = (rd_addr == AW'(i)) ? w_q[i] : w_rd;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= oen;
            if (oen) r_data <= w_rd;
            r_ovf <= |w_ovf;
        end
    end

    assign data_out  = r_data;
    assign out_valid = r_valid;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed + random checks of three reg_bank variants (wrap, saturate, DEPTH=5)
// against an array-based reference model.
module tb_reg_bank;
    logic       clk = 0, clr = 0, sclr = 0, inen = 0, inc = 0, oen = 0;
    logic [2:0] wa = 0, ra = 0;
    logic [3:0] din = 0;
    logic [3:0] d0, d1, d2;
    logic       v0, v1, v2, o0, o1, o2;
    int         n_assert = 0, n_fail = 0;
    int         mem [3][8];
    int         e_dout [3], e_val [3], e_ovf [3];

    always #5 clk = ~clk;

    reg_bank #(.WIDTH(4), .DEPTH(4), .WRAP(1)) u_wrap (
        .clk(clk), .clr(clr), .sclr(sclr), .inen(inen), .inc(inc), .wr_addr(wa[1:0]),
        .data_in(din), .oen(oen), .rd_addr(ra[1:0]), .data_out(d0), .out_valid(v0), .ovf(o0));
    reg_bank #(.WIDTH(4), .DEPTH(4), .WRAP(0)) u_sat (
        .clk(clk), .clr(clr), .sclr(sclr), .inen(inen), .inc(inc), .wr_addr(wa[1:0]),
        .data_in(din), .oen(oen), .rd_addr(ra[1:0]), .data_out(d1), .out_valid(v1), .ovf(o1));
    reg_bank #(.WIDTH(4), .DEPTH(5), .WRAP(1)) u_d5 (
        .clk(clk), .clr(clr), .sclr(sclr), .inen(inen), .inc(inc), .wr_addr(wa),
        .data_in(din), .oen(oen), .rd_addr(ra), .data_out(d2), .out_valid(v2), .ovf(o2));

    function automatic int dep(int k); return k == 2 ? 5 : 4; endfunction
    function automatic int wrp(int k); return k == 1 ? 0 : 1; endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 8; j++) mem[k][j] = 0;
            e_dout[k] = 0; e_val[k] = 0; e_ovf[k] = 0;
        end
    endtask

    task automatic model_edge();
        int w, r;
        for (int k = 0; k < 3; k++) begin
            w = k == 2 ? int'(wa) : int'(wa[1:0]);
            r = k == 2 ? int'(ra) : int'(ra[1:0]);
            e_val[k] = int'(oen);
            if (oen) e_dout[k] = r < dep(k) ? mem[k][r] : 0;
            e_ovf[k] = 0;
            if (sclr) for (int j = 0; j < 8; j++) mem[k][j] = 0;
            else if (inen) begin
                if (w < dep(k)) mem[k][w] = int'(din);
            end else if (inc && w < dep(k)) begin
                if (mem[k][w] == 15) begin
                    e_ovf[k] = 1;
                    mem[k][w] = wrp(k) != 0 ? 0 : 15;
                end else mem[k][w] = mem[k][w] + 1;
            end
        end
    endtask

    task automatic check_all();
        chk("dout_wrap", 32'(d0), e_dout[0]); chk("valid_wrap", 32'(v0), e_val[0]); chk("ovf_wrap", 32'(o0), e_ovf[0]);
        chk("dout_sat", 32'(d1), e_dout[1]);  chk("valid_sat", 32'(v1), e_val[1]);  chk("ovf_sat", 32'(o1), e_ovf[1]);
        chk("dout_d5", 32'(d2), e_dout[2]);   chk("valid_d5", 32'(v2), e_val[2]);   chk("ovf_d5", 32'(o2), e_ovf[2]);
    endtask

    task automatic drv(logic s, logic e, logic i, logic [2:0] w, logic [3:0] d, logic o, logic [2:0] r);
        sclr = s; inen = e; inc = i; wa = w; din = d; oen = o; ra = r;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    initial begin
        model_reset();
        #12 check_all();
        @(negedge clk) clr = 1;
        // write then read with one-cycle latency, then hold
        drv(0, 1, 0, 1, 4'h5, 0, 0); cyc();
        drv(0, 0, 0, 0, 4'h0, 1, 1); cyc();
        chk("rd_entry1", 32'(d0), 32'h5); chk("rd_valid", 32'(v0), 1);
        drv(0, 0, 0, 0, 4'h0, 0, 0); cyc();
        chk("hold_data", 32'(d0), 32'h5); chk("hold_valid", 32'(v0), 0);
        // E + two increments: wrap to 0 / saturate at F, single ovf pulse
        drv(0, 1, 0, 3, 4'hE, 0, 0); cyc();
        drv(0, 0, 1, 3, 4'h0, 0, 0); cyc();
        chk("no_ovf_first_inc", 32'(o0), 0);
        cyc();
        chk("ovf_wrap_pulse", 32'(o0), 1); chk("ovf_sat_pulse", 32'(o1), 1);
        drv(0, 0, 0, 0, 4'h0, 1, 3); cyc();
        chk("ovf_wrap_drop", 32'(o0), 0); chk("ovf_sat_drop", 32'(o1), 0);
        chk("wrap_value", 32'(d0), 32'h0); chk("sat_value", 32'(d1), 32'hF);
        // write beats increment even on an all-ones entry
        drv(0, 1, 0, 0, 4'hF, 0, 0); cyc();
        drv(0, 1, 1, 0, 4'h7, 0, 0); cyc();
        drv(0, 0, 0, 0, 4'h0, 1, 0); cyc();
        chk("prio_ovf", 32'(o0), 0); chk("prio_value", 32'(d0), 32'h7);
        // same-address read/write returns pre-update value
        drv(0, 1, 0, 2, 4'h3, 0, 0); cyc();
        drv(0, 1, 0, 2, 4'h9, 1, 2); cyc();
        chk("no_bypass", 32'(d0), 32'h3);
        drv(0, 0, 0, 0, 4'h0, 1, 2); cyc();
        chk("after_write", 32'(d0), 32'h9);
        // out-of-range write/increment/read on the DEPTH=5 bank
        drv(0, 1, 0, 6, 4'hC, 0, 0); cyc();
        drv(0, 0, 1, 7, 4'h0, 1, 6); cyc();
        chk("oor_read", 32'(d2), 0); chk("oor_valid", 32'(v2), 1); chk("oor_ovf", 32'(o2), 0);
        // sync clear with simultaneous read
        for (int j = 0; j < 4; j++) begin
            drv(0, 1, 0, 3'(j), j == 1 ? 4'hB : 4'(j + 2), 0, 0); cyc();
        end
        drv(1, 1, 1, 0, 4'h3, 1, 1); cyc();
        chk("sclr_read", 32'(d0), 32'hB);
        for (int j = 0; j < 4; j++) begin
            drv(0, 0, 0, 0, 4'h0, 1, 3'(j)); cyc();
            chk("after_sclr", 32'(d0), 0);
        end
        // async reset mid-cycle, no edge needed
        drv(0, 1, 0, 2, 4'hA, 0, 0); cyc();
        drv(0, 0, 0, 0, 4'h0, 1, 2); cyc();
        chk("pre_reset", 32'(d0), 32'hA);
        #2 clr = 0;
        model_reset();
        #1 check_all();
        @(negedge clk) clr = 1;
        drv(0, 0, 0, 0, 4'h0, 1, 2); cyc();
        chk("post_reset_rd", 32'(d0), 0); chk("post_reset_valid", 32'(v0), 1);
        // random traffic
        for (int n = 0; n < 400; n++) begin
            drv($urandom_range(99) < 3, $urandom_range(99) < 30, $urandom_range(99) < 50,
                3'($urandom), 4'($urandom_range(15)), $urandom_range(99) < 60, 3'($urandom));
            cyc();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 4, entry data width in bits (legal range 1..32).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries (legal range 2..16).
REQ-003 SHALL have parameter WRAP, default 1: 1 = increment wraps to 0 at all-ones; 0 = increment saturates.
REQ-004 SHALL derive AW = $clog2(DEPTH) as the address width.
REQ-005 SHALL have the following ports:
- clk, input, 1: the single clock; all state updates on the rising edge.
- clr, input, 1: reset, asynchronous, active-low.
- sclr, input, 1: synchronous clear of all entries.
- inen, input, 1: write enable.
- inc, input, 1: increment the entry at wr_addr.
- wr_addr, input, AW: write/increment address.
- data_in, input, WIDTH: write data.
- oen, input, 1: read request.
- rd_addr, input, AW: read address.
- data_out, output, WIDTH: registered read data.
- out_valid, output, 1: data_out updated this cycle.
- ovf, output, 1: one-cycle pulse when an increment hits the all-ones value.

Function
REQ-006 SHALL write data_in into entry wr_addr on a rising edge with inen=1.
REQ-007 SHALL replace entry wr_addr with entry+1 on a rising edge with inc=1 and inen=0.
REQ-008 SHALL give inen priority over inc when both are 1: the write happens, the increment is dropped, and ovf stays 0.
REQ-009 SHALL apply WRAP=1 for an increment of an all-ones entry: the entry becomes 0 and ovf=1 for the next cycle.
REQ-010 SHALL apply WRAP=0 for an increment of an all-ones entry: the entry holds all-ones and ovf=1 for the next cycle.
REQ-011 SHALL drive ovf from a register: 1 for exactly one cycle per overflowing increment, 0 otherwise.
REQ-012 SHALL read with one-cycle latency: on a rising edge with oen=1, data_out <= entry[rd_addr] and out_valid <= 1.
REQ-013 SHALL hold data_out at its last value and set out_valid <= 0 on any edge with oen=0 (no high-impedance output).
REQ-014 SHALL return the pre-update value when a read and a write/increment target the same address in the same cycle (no bypass).
REQ-015 SHALL treat sclr=1 as follows: all entries <= 0 and ovf <= 0; sclr overrides inen and inc in that cycle.
REQ-016 SHALL still perform a read under sclr=1 with oen=1, returning the pre-clear value.
REQ-017 SHALL ignore writes and increments to an address >= DEPTH (non-power-of-2 DEPTH); ovf SHALL stay 0 for them.
REQ-018 SHALL return data_out = 0 with out_valid = 1 for a read of an address >= DEPTH.
REQ-019 SHALL allow independent write and read ports in the same cycle, with no stalls.

Reset
REQ-020 SHALL, while clr=0, force asynchronously, independent of clk: all entries = 0, data_out = 0, out_valid = 0, ovf = 0.
REQ-021 SHALL abandon an operation in flight when clr asserts mid-operation, with no partial update visible after release.
REQ-022 SHALL accept operations on the first rising edge after clr deasserts.

Structure
REQ-023 SHALL place the parameter defaults (WIDTH, DEPTH, WRAP) and an op-encoding typedef (OP_NONE, OP_WRITE, OP_INC, OP_CLEAR) in shared package reg_bank_pkg.
REQ-024 SHALL instantiate one sub-module reg_cell per entry, DEPTH instances.
REQ-025 SHALL implement reg_cell as: WIDTH-bit register with clr, sclr, load, inc and WRAP parameter, producing a combinational overflow flag.
REQ-026 SHALL keep address decode, ovf registration and the read mux/output register in reg_bank.

Verification (WIDTH=4, DEPTH=4, WRAP=1 unless stated)
REQ-027 SHALL cover: clr=0 mid-run after writing 4'hA to entry 2 -> data_out=0, out_valid=0, ovf=0 immediately (no clock edge needed); a read of entry 2 after release -> 4'h0.
REQ-028 SHALL cover: write 4'h5 to entry 1, then oen=1 with rd_addr=1 the next cycle -> data_out=4'h5, out_valid=1 one cycle later; oen=0 after that -> data_out holds 4'h5, out_valid=0.
REQ-029 SHALL cover: write 4'hE to entry 3, then 2 increments -> entry reads 4'h0, ovf high for exactly one cycle after the second increment; repeat with WRAP=0 -> entry reads 4'hF, ovf pulses once.
REQ-030 SHALL cover: inen=1 and inc=1 to entry 0 with data_in=4'h7 -> entry 0 = 4'h7, ovf=0.
REQ-031 SHALL cover: entry 2 = 4'h3, then in one cycle write 4'h9 to entry 2 and read entry 2 -> data_out=4'h3; the next read returns 4'h9.
REQ-032 SHALL cover: all entries nonzero, then sclr=1 with oen=1 on entry 1 (value 4'hB) -> data_out=4'hB; all later reads return 4'h0.
